// File: rtl/cpu_defs.sv
// Shared encodings for the iterative multiply/divide unit.
package cpu_defs;

    localparam int DATA_W = 32;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
module div_step
    import cpu_defs::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit and keep the trial difference if it did not borrow.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        quo_bit = ~trial[WIDTH];
        rem_out = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit feeding the Z pair.
module iter_muldiv
    import cpu_defs::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      count;
    // Multiply: {P_hi, P_lo, q-1}. Divide: {0, remainder, dividend/quotient shift register}.
    logic [2*WIDTH:0]   acc;

    logic               accept;
    logic               calc_step;
    logic               commit;
    logic               start_dbz;

    logic [2*WIDTH:0]   acc_init;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH-1:0]   a_in_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rem_next;
    logic               quo_bit;
    logic               fix_dbz;
    logic [WIDTH-1:0]   fix_high;
    logic [WIDTH-1:0]   fix_low;

    assign start_dbz = (op_t'(op) == OP_DIV) && (operand_b == '0);

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = start_dbz ? FIXUP : CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM strobes for the datapath.
    always_comb begin
        accept    = (state == IDLE) && start;
        calc_step = (state == CALC);
        commit    = (state == FIXUP);
    end

    // Accumulator load value on the start edge.
    always_comb begin
        a_in_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
        if (op_t'(op) == OP_DIV) acc_init = {1'b0, {WIDTH{1'b0}}, a_in_mag};
        else                     acc_init = {{WIDTH{1'b0}}, operand_b, 1'b0};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (b_mag),
        .rem_out      (rem_next),
        .quo_bit      (quo_bit)
    );

    // One Booth step (add/subtract multiplicand, arithmetic shift) or one restoring step.
    always_comb begin
        b_mag = b_q[WIDTH-1] ? -b_q : b_q;
        case (acc[1:0])
            2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {a_q[WIDTH-1], a_q};
            2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {a_q[WIDTH-1], a_q};
            default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        endcase
        // The 33-bit sum is exact, so its LSB shifts into P_lo without overflow.
        if (op_q == OP_DIV) acc_step = {1'b0, rem_next, acc[WIDTH-2:0], quo_bit};
        else                acc_step = {booth_sum, acc[WIDTH:1]};
    end

    // Final sign correction and divide-by-zero result.
    always_comb begin
        fix_dbz  = (op_q == OP_DIV) && (b_q == '0);
        fix_high = acc[2*WIDTH:WIDTH+1];
        fix_low  = acc[WIDTH:1];
        if (fix_dbz) begin
            fix_high = a_q;
            fix_low  = '1;
        end else if (op_q == OP_DIV) begin
            fix_low  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_high = a_q[WIDTH-1] ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    // Operand latches, iteration, and registered outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            // NOTE: every datapath flop is reset so an abort leaves no stale result visible.
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            count       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            z_high      <= '0;
            z_low       <= '0;
        end else begin
            done <= commit;
            if (accept) begin
                op_q        <= op_t'(op);
                a_q         <= operand_a;
                b_q         <= operand_b;
                count       <= '0;
                acc         <= acc_init;
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
            end
            if (calc_step) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end
            if (commit) begin
                z_high      <= fix_high;
                z_low       <= fix_low;
                div_by_zero <= fix_dbz;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed self-checking bench for iter_muldiv.
module tb_iter_muldiv;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] z_high;
    logic [31:0] z_low;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    iter_muldiv #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z_high      (z_high),
        .z_low       (z_low)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; cyc counts edges after the start edge (edge 0), sampled at negedge.
    task automatic run_op(input string tag, input logic op_in, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat,
                          input logic exp_dbz);
        int cyc;
        int busy_cnt;
        logic dbz0;
        @(negedge clock);
        op = op_in; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        busy_cnt = 0;
        dbz0 = 1'bx;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clock);
            if (cyc == 0) dbz0 = div_by_zero;
            if (done) break;
            if (busy) busy_cnt++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_hi"}, 64'(z_high), 64'(exp_hi));
        check({tag, "_lo"}, 64'(z_low), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        if (!exp_dbz) check({tag, "_dbz_cleared_at_start"}, 64'(dbz0), 64'(0));
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        clear_n = 1'b0; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        check("rst_hi", 64'(z_high), 64'(0));
        check("rst_lo", 64'(z_low), 64'(0));
        @(negedge clock);
        clear_n = 1'b1;

        // Multiplies.
        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 1'b0);
        run_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, 1'b0);

        // Divides, truncating toward zero.
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33, 1'b0);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);

        // Divide by zero fast path, then a normal divide clears the flag at its start.
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b1);
        run_op("div_9_3", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 33, 1'b0);

        // Start/operand changes while busy are ignored; start in the done cycle is accepted.
        @(negedge clock);
        op = 1'b0; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        done_cnt = 0; first_done = -1; second_done = -1;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clock);
            if (cyc == 5) begin
                op = 1'b1; operand_b = 32'd99; start = 1'b1;
            end else if (cyc == 6) begin
                start = 1'b0;
            end
            if (cyc == 34) begin
                start = 1'b0;
                check("b2b_done_drops", 64'(done), 64'(0));
                check("b2b_z_holds", {z_high, z_low}, 64'd12);
            end
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = cyc;
                    check("busy_ignore_hi", 64'(z_high), 64'(0));
                    check("busy_ignore_lo", 64'(z_low), 64'(12));
                    op = 1'b0; operand_a = 32'hFFFF_FFFB; operand_b = 32'd11; start = 1'b1;
                end else begin
                    second_done = cyc;
                end
            end
        end
        check("busy_ignore_first_done", 64'(first_done), 64'(33));
        check("b2b_second_done", 64'(second_done), 64'(67));
        check("b2b_done_count", 64'(done_cnt), 64'(2));
        check("b2b_hi", 64'(z_high), 64'hFFFF_FFFF);
        check("b2b_lo", 64'(z_low), 64'hFFFF_FFC9);

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        op = 1'b1; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (11) @(negedge clock);
        clear_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_hi", 64'(z_high), 64'(0));
        check("abort_lo", 64'(z_low), 64'(0));
        @(negedge clock);
        clear_n = 1'b1;
        done_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));
        run_op("mul_6_6", 1'b0, 32'd6, 32'd6, 32'd0, 32'd36, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
